// File: rtl/math_pkg.sv
// Shared defaults, FSM state encoding and error-bit positions
// for the vector normalizer and its arithmetic helpers.
package math_pkg;
  localparam int WIDTH_DEF = 32;
  localparam int FBITS_DEF = 8;
  localparam int ERR_DBZ = 0;
  localparam int ERR_OVF = 1;

  typedef enum logic [2:0] {
    IDLE,
    SQ,
    SQRT_GO,
    SQRT_WAIT,
    DIV_GO,
    DIV_WAIT,
    OUT
  } norm_state_t;
endpackage

// File: rtl/div.sv
// Signed fixed-point divider (a << FBITS) / b, restoring, one
// quotient bit per cycle; reports valid, dbz or ovf with done.
module div #(
  parameter int WIDTH = 32,
  parameter int FBITS = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  output logic                    done,
  output logic                    valid,
  output logic                    dbz,
  output logic                    ovf,
  output logic signed [WIDTH-1:0] val
);
  localparam int N  = WIDTH + FBITS;
  localparam int CW = $clog2(N + 1);
  localparam logic [WIDTH-1:0] PMAX = {1'b0, {(WIDTH - 1){1'b1}}};
  localparam logic [WIDTH-1:0] NMAX = {1'b1, {(WIDTH - 2){1'b0}}, 1'b1};
  localparam logic [N-1:0] LIM = {{(FBITS + 1){1'b0}}, {(WIDTH - 1){1'b1}}};

  logic [N-1:0]     d;
  logic [N-1:0]     qq;
  logic [N-1:0]     q_n;
  logic [WIDTH-1:0] dv;
  logic [WIDTH-1:0] rem;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   rem_n;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic [CW-1:0]    cnt;
  logic             neg;
  logic             busy;
  logic             ge;
  logic             q_big;

  assign abs_a  = a[WIDTH-1] ? WIDTH'(-a) : a;
  assign abs_b  = b[WIDTH-1] ? WIDTH'(-b) : b;
  assign rem_sh = {rem, d[N-1]};
  assign ge     = rem_sh >= {1'b0, dv};
  assign rem_n  = ge ? rem_sh - {1'b0, dv} : rem_sh;
  assign q_n    = {qq[N-2:0], ge};
  // a negative result may reach one LSB further than a positive one
  assign q_big  = q_n > (LIM + N'(neg));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d     <= '0;
      qq    <= '0;
      dv    <= '0;
      rem   <= '0;
      cnt   <= '0;
      neg   <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      valid <= 1'b0;
      dbz   <= 1'b0;
      ovf   <= 1'b0;
      val   <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        valid <= 1'b0;
        ovf   <= 1'b0;
        if (b == '0) begin
          done <= 1'b1;
          dbz  <= 1'b1;
          val  <= '0;
          busy <= 1'b0;
        end else begin
          dbz  <= 1'b0;
          d    <= {abs_a, {FBITS{1'b0}}};
          qq   <= '0;
          rem  <= '0;
          dv   <= abs_b;
          neg  <= a[WIDTH-1] ^ b[WIDTH-1];
          cnt  <= CW'(N);
          busy <= 1'b1;
        end
      end else if (busy) begin
        d   <= {d[N-2:0], 1'b0};
        rem <= rem_n[WIDTH-1:0];
        qq  <= q_n;
        cnt <= cnt - CW'(1);
        if (cnt == CW'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
          if (q_big) begin
            ovf <= 1'b1;
            val <= neg ? NMAX : PMAX;
          end else begin
            valid <= 1'b1;
            val   <= neg ? -q_n[WIDTH-1:0] : q_n[WIDTH-1:0];
          end
        end
      end
    end
  end
endmodule

// File: rtl/sq_accum.sv
// Three-cycle sum of squares through one shared multiplier,
// saturating to all-ones with a sticky overflow flag.
module sq_accum #(
  parameter int WIDTH = 32,
  parameter int FBITS = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    en,
  input  logic signed [WIDTH-1:0] x,
  input  logic signed [WIDTH-1:0] y,
  input  logic signed [WIDTH-1:0] z,
  output logic                    last,
  output logic [WIDTH-1:0]        acc,
  output logic                    ovf
);
  localparam int W2 = 2 * WIDTH;

  logic [1:0]             k;
  logic signed [WIDTH-1:0] c;
  logic signed [W2-1:0]   cw;
  logic signed [W2-1:0]   prod;
  logic [W2-1:0]          term;
  logic [W2:0]            sum;
  logic                   carry;

  always_comb begin
    c = x;
    unique case (k)
      2'd1:    c = y;
      2'd2:    c = z;
      default: c = x;
    endcase
  end

  assign cw    = W2'(c);
  assign prod  = cw * cw;
  assign term  = $unsigned(prod) >> FBITS;
  assign sum   = {1'b0, term} + {{(WIDTH + 1){1'b0}}, acc};
  // any bit above WIDTH, from the term or the add, is a carry-out
  assign carry = |sum[W2:WIDTH];
  assign last  = en && (k == 2'd2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k   <= '0;
      acc <= '0;
      ovf <= 1'b0;
    end else if (clr) begin
      k   <= '0;
      acc <= '0;
      ovf <= 1'b0;
    end else if (en) begin
      acc <= carry ? '1 : sum[WIDTH-1:0];
      ovf <= ovf | carry;
      k   <= (k == 2'd2) ? 2'd0 : k + 2'd1;
    end
  end
endmodule

// File: rtl/sqrt.sv
// Digit-recurrence fixed-point square root, two radicand bits
// per cycle; no reset, so valid is only meaningful after start.
module sqrt #(
  parameter int WIDTH = 32,
  parameter int FBITS = 8
) (
  input  logic             clk,
  input  logic             start,
  input  logic [WIDTH-1:0] rad,
  output logic [WIDTH-1:0] root,
  output logic             busy,
  output logic             valid
);
  localparam int N    = (WIDTH + FBITS + 1) / 2 * 2;
  localparam int ITER = N / 2;
  localparam int RW   = ITER + 4;
  localparam int CW   = $clog2(ITER + 1);

  logic [N-1:0]    xs;
  logic [RW-1:0]   rem;
  logic [RW-1:0]   rem_sh;
  logic [RW-1:0]   trial;
  logic [ITER-1:0] q;
  logic [CW-1:0]   cnt;
  logic            ge;

  assign rem_sh = {rem[RW-3:0], xs[N-1:N-2]};
  assign trial  = {{(RW - ITER - 2){1'b0}}, q, 2'b01};
  assign ge     = rem_sh >= trial;
  assign root   = WIDTH'(q);

  always_ff @(posedge clk) begin
    if (start) begin
      xs    <= N'(rad) << FBITS;
      rem   <= '0;
      q     <= '0;
      cnt   <= CW'(ITER);
      busy  <= 1'b1;
      valid <= 1'b0;
    end else if (busy) begin
      xs  <= {xs[N-3:0], 2'b00};
      rem <= ge ? rem_sh - trial : rem_sh;
      q   <= {q[ITER-2:0], ge};
      cnt <= cnt - CW'(1);
      if (cnt == CW'(1)) begin
        busy  <= 1'b0;
        valid <= 1'b1;
      end
    end
  end
endmodule

// File: rtl/vec_normalize.sv
// 3-D vector normalizer: sum of squares, sqrt for magnitude,
// then one divide per component, with sticky error flags.
module vec_normalize
  import math_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int FBITS = FBITS_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] in_x,
  input  logic signed [WIDTH-1:0] in_y,
  input  logic signed [WIDTH-1:0] in_z,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] out_x,
  output logic signed [WIDTH-1:0] out_y,
  output logic signed [WIDTH-1:0] out_z,
  output logic [WIDTH-1:0]        out_mag,
  output logic [1:0]              out_err,
  output logic                    busy
);
  norm_state_t state, state_n;

  logic [1:0]              idx;
  logic signed [WIDTH-1:0] cx, cy, cz, comp, res;
  logic [1:0]              err;
  logic                    sqrt_issued;

  logic             sq_clr, sq_en, sq_last, sq_ovf;
  logic [WIDTH-1:0] acc;
  logic             sqrt_start, sqrt_busy, sqrt_valid, sqrt_ok;
  logic [WIDTH-1:0] root;
  logic             div_start, div_done, div_valid, div_dbz, div_ovf;
  logic signed [WIDTH-1:0] div_val;

  function automatic logic [WIDTH-1:0] sat_of(input logic s);
    return s ? {1'b1, {(WIDTH - 2){1'b0}}, 1'b1}
             : {1'b0, {(WIDTH - 1){1'b1}}};
  endfunction

  sq_accum #(.WIDTH(WIDTH), .FBITS(FBITS)) u_sq (
    .clk(clk), .rst_n(rst_n), .clr(sq_clr), .en(sq_en),
    .x(cx), .y(cy), .z(cz),
    .last(sq_last), .acc(acc), .ovf(sq_ovf)
  );

  sqrt #(.WIDTH(WIDTH), .FBITS(FBITS)) u_sqrt (
    .clk(clk), .start(sqrt_start), .rad(acc),
    .root(root), .busy(sqrt_busy), .valid(sqrt_valid)
  );

  div #(.WIDTH(WIDTH), .FBITS(FBITS)) u_div (
    .clk(clk), .rst(~rst_n), .start(div_start),
    .a(comp), .b($signed(out_mag)),
    .done(div_done), .valid(div_valid), .dbz(div_dbz),
    .ovf(div_ovf), .val(div_val)
  );

  // sqrt keeps no reset, so only trust it after our own start
  assign sqrt_ok   = sqrt_issued && sqrt_valid && !sqrt_busy;
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == OUT);
  assign busy      = (state != IDLE) && (state != OUT);
  assign out_err   = err;

  always_comb begin
    comp = cx;
    unique case (idx)
      2'd1:    comp = cy;
      2'd2:    comp = cz;
      default: comp = cx;
    endcase
  end

  always_comb begin
    res = '0;
    if (div_valid)    res = div_val;
    else if (div_ovf) res = sat_of(comp[WIDTH-1]);
  end

  always_comb begin
    state_n    = state;
    sq_clr     = 1'b0;
    sq_en      = 1'b0;
    sqrt_start = 1'b0;
    div_start  = 1'b0;
    unique case (state)
      IDLE: if (in_valid) begin
        sq_clr  = 1'b1;
        state_n = SQ;
      end
      SQ: begin
        sq_en = 1'b1;
        if (sq_last) state_n = SQRT_GO;
      end
      SQRT_GO: begin
        sqrt_start = 1'b1;
        state_n    = SQRT_WAIT;
      end
      SQRT_WAIT: if (sqrt_ok)
        state_n = root[WIDTH-1] ? OUT : DIV_GO;
      DIV_GO: begin
        div_start = 1'b1;
        state_n   = DIV_WAIT;
      end
      DIV_WAIT: if (div_done)
        state_n = (idx == 2'd2) ? OUT : DIV_GO;
      OUT: if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx         <= '0;
      cx          <= '0;
      cy          <= '0;
      cz          <= '0;
      out_x       <= '0;
      out_y       <= '0;
      out_z       <= '0;
      out_mag     <= '0;
      err         <= '0;
      sqrt_issued <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          cx          <= in_x;
          cy          <= in_y;
          cz          <= in_z;
          idx         <= '0;
          sqrt_issued <= 1'b0;
        end
        SQRT_GO: begin
          sqrt_issued <= 1'b1;
          if (sq_ovf) err[ERR_OVF] <= 1'b1;
        end
        SQRT_WAIT: if (sqrt_ok) begin
          out_mag <= root;
          idx     <= '0;
          // a magnitude that is negative as a divisor skips the divides
          if (root[WIDTH-1]) begin
            err[ERR_OVF] <= 1'b1;
            out_x <= sat_of(cx[WIDTH-1]);
            out_y <= sat_of(cy[WIDTH-1]);
            out_z <= sat_of(cz[WIDTH-1]);
          end
        end
        DIV_WAIT: if (div_done) begin
          if (div_dbz) err[ERR_DBZ] <= 1'b1;
          if (div_ovf) err[ERR_OVF] <= 1'b1;
          case (idx)
            2'd0:    out_x <= res;
            2'd1:    out_y <= res;
            default: out_z <= res;
          endcase
          idx <= (idx == 2'd2) ? 2'd0 : idx + 2'd1;
        end
        OUT: if (out_ready) begin
          err         <= '0;
          sqrt_issued <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_vec_normalize.sv
// Randomized bench for vec_normalize against an arithmetic
// reference of normalization (sum of squares, isqrt, divide).
module tb_vec_normalize;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [31:0] in_x, in_y, in_z;
  logic        out_valid, out_ready;
  logic [31:0] out_x, out_y, out_z, out_mag;
  logic [1:0]  out_err;
  logic        busy;

  int n_chk = 0;
  int n_err = 0;
  logic [31:0] last_x, last_y, last_z, last_mag;
  logic [1:0]  last_err;

  vec_normalize dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y), .in_z(in_z),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_x(out_x), .out_y(out_y), .out_z(out_z),
    .out_mag(out_mag), .out_err(out_err), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit hit");
    $fatal(1);
  end

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic longint unsigned isqrt(input longint unsigned v);
    longint unsigned r = 0;
    longint unsigned t;
    for (int b = 31; b >= 0; b--) begin
      t = r | (64'd1 << b);
      if (t * t <= v) r = t;
    end
    return r;
  endfunction

  task automatic model(input logic [31:0] x, y, z,
                       output logic [31:0] ox, oy, oz, om,
                       output logic [1:0] oe);
    longint c[3];
    longint unsigned acc, s, mag, num, q;
    logic [31:0] r[3];
    bit neg;
    c[0] = longint'($signed(x));
    c[1] = longint'($signed(y));
    c[2] = longint'($signed(z));
    acc = 0;
    oe  = 2'b00;
    for (int i = 0; i < 3; i++) begin
      s = acc + longint'(unsigned'((c[i] * c[i]) >> 8));
      if (s > 64'hFFFF_FFFF) begin
        acc = 64'hFFFF_FFFF;
        oe[1] = 1'b1;
      end else acc = s;
    end
    mag = isqrt(acc << 8);
    for (int i = 0; i < 3; i++) begin
      neg = c[i] < 0;
      if (mag >= 64'h8000_0000) begin
        oe[1] = 1'b1;
        r[i] = neg ? 32'h8000_0001 : 32'h7FFF_FFFF;
      end else if (mag == 0) begin
        oe[0] = 1'b1;
        r[i] = 32'h0;
      end else begin
        num = (neg ? -c[i] : c[i]) << 8;
        q = num / mag;
        if (q > (neg ? 64'h8000_0000 : 64'h7FFF_FFFF)) begin
          oe[1] = 1'b1;
          r[i] = neg ? 32'h8000_0001 : 32'h7FFF_FFFF;
        end else begin
          r[i] = neg ? 32'(-q) : 32'(q);
        end
      end
    end
    ox = r[0];
    oy = r[1];
    oz = r[2];
    om = 32'(mag);
  endtask

  // called at a negedge; returns at the negedge after the accept
  task automatic send(input string tag, input logic [31:0] x, y, z);
    int n = 0;
    in_valid = 1'b1;
    in_x = x;
    in_y = y;
    in_z = z;
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    check({tag, ".accept"}, 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input string tag);
    int n = 1;
    while (!out_valid && n <= 200) begin
      @(negedge clk);
      n++;
    end
    check({tag, ".latency_le_170"}, 64'(n <= 170), 64'd1);
  endtask

  task automatic check_out(input string tag, input logic [31:0] x, y, z);
    logic [31:0] ex, ey, ez, em;
    logic [1:0]  ee;
    model(x, y, z, ex, ey, ez, em, ee);
    last_x   = out_x;
    last_y   = out_y;
    last_z   = out_z;
    last_mag = out_mag;
    last_err = out_err;
    check({tag, ".mag"}, 64'(out_mag), 64'(em));
    check({tag, ".x"},   64'(out_x),   64'(ex));
    check({tag, ".y"},   64'(out_y),   64'(ey));
    check({tag, ".z"},   64'(out_z),   64'(ez));
    check({tag, ".err"}, 64'(out_err), 64'(ee));
  endtask

  task automatic accept_out();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic run_vec(input string tag, input logic [31:0] x, y, z);
    send(tag, x, y, z);
    wait_out(tag);
    check_out(tag, x, y, z);
    accept_out();
  endtask

  initial begin
    logic [31:0] hx, hy, hz, hm;
    logic [1:0]  he;
    bit stable;
    int r0, r1, r2;

    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_x = '0;
    in_y = '0;
    in_z = '0;
    repeat (3) @(negedge clk);
    check("rst.in_ready",  64'(in_ready),  64'd1);
    check("rst.out_valid", 64'(out_valid), 64'd0);
    check("rst.busy",      64'(busy),      64'd0);
    check("rst.out_x",     64'(out_x),     64'd0);
    check("rst.out_y",     64'(out_y),     64'd0);
    check("rst.out_z",     64'(out_z),     64'd0);
    check("rst.out_mag",   64'(out_mag),   64'd0);
    check("rst.out_err",   64'(out_err),   64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_vec("v345", 32'h300, 32'h400, 32'h0);
    check("v345.mag_const", 64'(last_mag), 64'h500);
    check("v345.x_near_0p6",
          64'(last_x >= 32'h98 && last_x <= 32'h9A), 64'd1);
    check("v345.y_near_0p8",
          64'(last_y >= 32'hCC && last_y <= 32'hCE), 64'd1);

    run_vec("zero", 32'h0, 32'h0, 32'h0);
    check("zero.err_const", 64'(last_err), 64'd1);

    run_vec("neg2", 32'hFFFF_FE00, 32'h0, 32'h0);
    check("neg2.mag_const", 64'(last_mag), 64'h200);
    check("neg2.x_const",   64'(last_x),   64'hFFFF_FF00);

    run_vec("sat", 32'h7FFF_FF00, 32'h7FFF_FF00, 32'h7FFF_FF00);
    check("sat.ovf_bit", 64'(last_err[1]), 64'd1);

    // reset while the square root is in flight
    send("midrst", 32'h300, 32'h400, 32'h0);
    repeat (10) @(negedge clk);
    check("midrst.busy_before", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check("midrst.in_ready", 64'(in_ready), 64'd1);
    check("midrst.busy",     64'(busy),     64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_vec("after_rst", 32'h100, 32'h0, 32'h0);
    check("after_rst.mag_const", 64'(last_mag), 64'h100);
    check("after_rst.x_const",   64'(last_x),   64'h100);
    check("after_rst.err_const", 64'(last_err), 64'd0);

    // backpressure: hold result, ignore a pending second vector
    send("bp1", 32'h0000_0280, 32'hFFFF_FD00, 32'h0000_0100);
    wait_out("bp1");
    check_out("bp1", 32'h0000_0280, 32'hFFFF_FD00, 32'h0000_0100);
    hx = out_x;
    hy = out_y;
    hz = out_z;
    hm = out_mag;
    he = out_err;
    in_valid = 1'b1;
    in_x = 32'h0000_0500;
    in_y = 32'h0000_0200;
    in_z = 32'hFFFF_F800;
    stable = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (out_x !== hx || out_y !== hy || out_z !== hz ||
          out_mag !== hm || out_err !== he ||
          in_ready !== 1'b0 || out_valid !== 1'b1)
        stable = 1'b0;
    end
    check("bp.hold_stable", 64'(stable), 64'd1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp.idle_after_out", 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    wait_out("bp2");
    check_out("bp2", 32'h0000_0500, 32'h0000_0200, 32'hFFFF_F800);
    accept_out();

    for (int i = 0; i < 12; i++) begin
      r0 = int'($urandom_range(0, 131072)) - 65536;
      r1 = int'($urandom_range(0, 131072)) - 65536;
      r2 = ($urandom_range(0, 3) == 0) ? 0
           : int'($urandom_range(0, 131072)) - 65536;
      run_vec($sformatf("rnd%0d", i), 32'(r0), 32'(r1), 32'(r2));
    end
    for (int i = 0; i < 4; i++) begin
      run_vec($sformatf("wide%0d", i), $urandom, $urandom, $urandom);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
